// File: rtl/eight_bit_four_reg_scan_module.sv
// Four-entry register bank with a valid/ready select sequencer feeding an external 4:1 mux.
// Optional continuous scanning is enabled by defining SCAN_WRAP_EN.
module eight_bit_four_reg_scan_module #(
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [1:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              start,
   input  logic              out_ready,
   output logic [DATA_W-1:0] reg_a,
   output logic [DATA_W-1:0] reg_b,
   output logic [DATA_W-1:0] reg_c,
   output logic [DATA_W-1:0] reg_d,
   output logic              s0,
   output logic              s1,
   output logic              out_valid,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [1:0]        idx_reg, idx_next;
   logic [DATA_W-1:0] bank_reg [0:3];
   logic              handshake;
   logic              hazard;

   assign handshake = (state_reg == SCAN) && out_ready;

   // A stalled entry must not change under the consumer, so writes to it are refused.
   assign hazard = out_valid && !out_ready && (wr_addr == idx_reg);
   assign wr_ack = wr_en && !hazard;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bank
         always_ff @(posedge clk) begin
            if (reset) begin
               bank_reg[gi] <= RESET_VAL;
            end else if (wr_ack && (wr_addr == 2'(gi))) begin
               bank_reg[gi] <= wr_data;
            end
         end
      end
   endgenerate

   assign reg_a = bank_reg[0];
   assign reg_b = bank_reg[1];
   assign reg_c = bank_reg[2];
   assign reg_d = bank_reg[3];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         idx_reg   <= 2'd0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

`ifdef SCAN_WRAP_EN
   logic stop_pending_reg;
   logic pass_done_reg;

   // A stop request made while stalled is remembered until the pending handshake lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         stop_pending_reg <= 1'b0;
         pass_done_reg    <= 1'b0;
      end else begin
         pass_done_reg <= handshake && (idx_reg == 2'd3);
         if (state_reg != SCAN || handshake) begin
            stop_pending_reg <= 1'b0;
         end else if (start) begin
            stop_pending_reg <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      case (state_reg)
         IDLE: begin
            idx_next = 2'd0;
            if (start) begin
               state_next = SCAN;
            end
         end
         SCAN: begin
            if (handshake) begin
               idx_next = idx_reg + 2'd1;
               if (start || stop_pending_reg) begin
                  state_next = IDLE;
                  idx_next   = 2'd0;
               end
            end
         end
         default: begin
            state_next = IDLE;
            idx_next   = 2'd0;
         end
      endcase
   end

   always_comb begin
      out_valid = (state_reg == SCAN);
      busy      = (state_reg == SCAN);
      done      = pass_done_reg;
      s0        = idx_reg[0];
      s1        = idx_reg[1];
   end
`else
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      case (state_reg)
         IDLE: begin
            idx_next = 2'd0;
            if (start) begin
               state_next = SCAN;
            end
         end
         SCAN: begin
            if (handshake) begin
               idx_next = idx_reg + 2'd1;
               if (idx_reg == 2'd3) begin
                  state_next = DONE;
               end
            end
         end
         default: begin
            state_next = IDLE;
            idx_next   = 2'd0;
         end
      endcase
   end

   always_comb begin
      out_valid = (state_reg == SCAN);
      busy      = (state_reg == SCAN);
      done      = (state_reg == DONE);
      s0        = idx_reg[0];
      s1        = idx_reg[1];
   end
`endif

endmodule
